// File: rtl/tilelink_pkg.sv
// Shared TileLink network-acquire types and constants for the acquire arbiter slice.
package tilelink_pkg;

   localparam logic [2:0]  ACQ_PUT_BLOCK   = 3'h3;
   localparam int unsigned BEATS_PER_BLOCK = 8;
   localparam int unsigned BEAT_W          = 3;
   localparam int unsigned ADDR_BLOCK_W    = 26;
   localparam int unsigned UNION_W         = 12;
   localparam int unsigned DATA_W          = 64;
   localparam int unsigned HDR_W           = 2;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_BLOCK - 1);

   typedef struct packed {
      logic [ADDR_BLOCK_W-1:0] addr_block;
      logic                    client_xact_id;
      logic [BEAT_W-1:0]       addr_beat;
      logic                    is_builtin_type;
      logic [2:0]              a_type;
      logic [UNION_W-1:0]      union_bits;
      logic [DATA_W-1:0]       data;
   } acq_payload_t;

   typedef struct packed {
      logic [HDR_W-1:0] src;
      logic [HDR_W-1:0] dst;
      acq_payload_t     payload;
   } net_acquire_t;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } lock_state_e;

   function automatic logic is_multibeat(input logic builtin, input logic [2:0] a_type);
      return builtin && (a_type == ACQ_PUT_BLOCK);
   endfunction

endpackage

// File: rtl/net_acquire_queue_2.sv
// Two-entry circular queue of network acquires; head entry drives the output directly.
module net_acquire_queue_2
   import tilelink_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enq,
   input  net_acquire_t enq_data,
   output logic         full,
   input  logic         deq_ready,
   output logic         deq_valid,
   output net_acquire_t deq_data
);

   net_acquire_t mem [DEPTH];
   logic         head;
   logic         tail;
   logic [1:0]   count;
   logic         wr;
   logic         rd;

   assign full      = (count == 2'd2);
   assign deq_valid = (count != 2'd0);
   assign deq_data  = mem[head];
   assign wr        = enq & ~full;
   assign rd        = deq_ready & deq_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (wr) tail <= ~tail;
         if (rd) head <= ~head;
         case ({wr, rd})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage is not reset; it is only observed while count != 0.
   always_ff @(posedge clk) begin
      if (wr) mem[tail] <= enq_data;
   end

endmodule

// File: rtl/acquire_network_arbiter_2.sv
// Round-robin merge of two client acquire streams with putBlock locking, into a 2-entry output queue.
module acquire_network_arbiter_2
   import tilelink_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic                    io_in_0_ready,
   input  logic                    io_in_0_valid,
   input  logic [HDR_W-1:0]        io_in_0_bits_header_src,
   input  logic [HDR_W-1:0]        io_in_0_bits_header_dst,
   input  logic [ADDR_BLOCK_W-1:0] io_in_0_bits_payload_addr_block,
   input  logic [0:0]              io_in_0_bits_payload_client_xact_id,
   input  logic [BEAT_W-1:0]       io_in_0_bits_payload_addr_beat,
   input  logic [0:0]              io_in_0_bits_payload_is_builtin_type,
   input  logic [2:0]              io_in_0_bits_payload_a_type,
   input  logic [UNION_W-1:0]      io_in_0_bits_payload_union,
   input  logic [DATA_W-1:0]       io_in_0_bits_payload_data,
   output logic                    io_in_1_ready,
   input  logic                    io_in_1_valid,
   input  logic [HDR_W-1:0]        io_in_1_bits_header_src,
   input  logic [HDR_W-1:0]        io_in_1_bits_header_dst,
   input  logic [ADDR_BLOCK_W-1:0] io_in_1_bits_payload_addr_block,
   input  logic [0:0]              io_in_1_bits_payload_client_xact_id,
   input  logic [BEAT_W-1:0]       io_in_1_bits_payload_addr_beat,
   input  logic [0:0]              io_in_1_bits_payload_is_builtin_type,
   input  logic [2:0]              io_in_1_bits_payload_a_type,
   input  logic [UNION_W-1:0]      io_in_1_bits_payload_union,
   input  logic [DATA_W-1:0]       io_in_1_bits_payload_data,
   input  logic                    io_out_ready,
   output logic                    io_out_valid,
   output logic [HDR_W-1:0]        io_out_bits_header_src,
   output logic [HDR_W-1:0]        io_out_bits_header_dst,
   output logic [ADDR_BLOCK_W-1:0] io_out_bits_payload_addr_block,
   output logic [0:0]              io_out_bits_payload_client_xact_id,
   output logic [BEAT_W-1:0]       io_out_bits_payload_addr_beat,
   output logic [0:0]              io_out_bits_payload_is_builtin_type,
   output logic [2:0]              io_out_bits_payload_a_type,
   output logic [UNION_W-1:0]      io_out_bits_payload_union,
   output logic [DATA_W-1:0]       io_out_bits_payload_data,
   output logic                    io_lock_active
);

   net_acquire_t in_pkt [2];
   net_acquire_t sel;
   net_acquire_t head;
   lock_state_e  state, state_next;
   logic         lock_owner, owner_next;
   logic         rr_ptr, rr_next;
   logic [1:0]   valid, grant, ready;
   logic         q_full, fire, winner, sel_multi, sel_last;

   assign in_pkt[0] = '{src: io_in_0_bits_header_src, dst: io_in_0_bits_header_dst,
                        payload: '{addr_block: io_in_0_bits_payload_addr_block,
                                   client_xact_id: io_in_0_bits_payload_client_xact_id,
                                   addr_beat: io_in_0_bits_payload_addr_beat,
                                   is_builtin_type: io_in_0_bits_payload_is_builtin_type,
                                   a_type: io_in_0_bits_payload_a_type,
                                   union_bits: io_in_0_bits_payload_union,
                                   data: io_in_0_bits_payload_data}};
   assign in_pkt[1] = '{src: io_in_1_bits_header_src, dst: io_in_1_bits_header_dst,
                        payload: '{addr_block: io_in_1_bits_payload_addr_block,
                                   client_xact_id: io_in_1_bits_payload_client_xact_id,
                                   addr_beat: io_in_1_bits_payload_addr_beat,
                                   is_builtin_type: io_in_1_bits_payload_is_builtin_type,
                                   a_type: io_in_1_bits_payload_a_type,
                                   union_bits: io_in_1_bits_payload_union,
                                   data: io_in_1_bits_payload_data}};

   assign valid = {io_in_1_valid, io_in_0_valid};

   always_comb begin
      grant = '0;
      if (state == ST_LOCKED) grant[lock_owner] = valid[lock_owner];
      else if (&valid)        grant[rr_ptr]     = 1'b1;
      else                    grant             = valid;
   end

   // Ready is held low while reset is asserted so the reset values hold regardless of input valids.
   assign ready         = grant & {2{~q_full & ~reset}};
   assign io_in_0_ready = ready[0];
   assign io_in_1_ready = ready[1];
   assign fire          = |ready;
   assign winner        = ready[1];
   assign sel           = winner ? in_pkt[1] : in_pkt[0];
   assign sel_multi     = is_multibeat(sel.payload.is_builtin_type, sel.payload.a_type);
   assign sel_last      = (sel.payload.addr_beat == LAST_BEAT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         lock_owner <= 1'b0;
         rr_ptr     <= 1'b0;
      end else begin
         state      <= state_next;
         lock_owner <= owner_next;
         rr_ptr     <= rr_next;
      end
   end

   always_comb begin
      state_next = state;
      owner_next = lock_owner;
      rr_next    = rr_ptr;
      if (fire) begin
         case (state)
            ST_IDLE: begin
               rr_next = ~winner;
               if (sel_multi && !sel_last) begin
                  state_next = ST_LOCKED;
                  owner_next = winner;
               end
            end
            ST_LOCKED: begin
               if (sel_last) begin
                  state_next = ST_IDLE;
                  rr_next    = ~lock_owner;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   assign io_lock_active = (state == ST_LOCKED);

   net_acquire_queue_2 #(.DEPTH(DEPTH)) u_queue (
      .clk       (clk),
      .reset     (reset),
      .enq       (fire),
      .enq_data  (sel),
      .full      (q_full),
      .deq_ready (io_out_ready),
      .deq_valid (io_out_valid),
      .deq_data  (head)
   );

   assign io_out_bits_header_src              = head.src;
   assign io_out_bits_header_dst              = head.dst;
   assign io_out_bits_payload_addr_block      = head.payload.addr_block;
   assign io_out_bits_payload_client_xact_id  = head.payload.client_xact_id;
   assign io_out_bits_payload_addr_beat       = head.payload.addr_beat;
   assign io_out_bits_payload_is_builtin_type = head.payload.is_builtin_type;
   assign io_out_bits_payload_a_type          = head.payload.a_type;
   assign io_out_bits_payload_union           = head.payload.union_bits;
   assign io_out_bits_payload_data            = head.payload.data;

endmodule

// File: tb/tb_acquire_network_arbiter_2.sv
// Directed bench for acquire_network_arbiter_2: interleave, putBlock lock, backpressure, degenerate beat, mid-burst reset.
module tb_acquire_network_arbiter_2;
   import tilelink_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic v0, v1, r0, r1, out_ready, out_valid, lock;
   net_acquire_t in0, in1;
   logic [HDR_W-1:0]        out_src, out_dst;
   logic [ADDR_BLOCK_W-1:0] out_addr_block;
   logic [0:0]              out_xact, out_builtin;
   logic [BEAT_W-1:0]       out_beat;
   logic [2:0]              out_atype;
   logic [UNION_W-1:0]      out_union;
   logic [DATA_W-1:0]       out_data;
   int unsigned passed = 0;
   int unsigned total  = 0;

   always #5 clk = ~clk;

   acquire_network_arbiter_2 #(.DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .io_in_0_ready(r0), .io_in_0_valid(v0),
      .io_in_0_bits_header_src(in0.src), .io_in_0_bits_header_dst(in0.dst),
      .io_in_0_bits_payload_addr_block(in0.payload.addr_block),
      .io_in_0_bits_payload_client_xact_id(in0.payload.client_xact_id),
      .io_in_0_bits_payload_addr_beat(in0.payload.addr_beat),
      .io_in_0_bits_payload_is_builtin_type(in0.payload.is_builtin_type),
      .io_in_0_bits_payload_a_type(in0.payload.a_type),
      .io_in_0_bits_payload_union(in0.payload.union_bits),
      .io_in_0_bits_payload_data(in0.payload.data),
      .io_in_1_ready(r1), .io_in_1_valid(v1),
      .io_in_1_bits_header_src(in1.src), .io_in_1_bits_header_dst(in1.dst),
      .io_in_1_bits_payload_addr_block(in1.payload.addr_block),
      .io_in_1_bits_payload_client_xact_id(in1.payload.client_xact_id),
      .io_in_1_bits_payload_addr_beat(in1.payload.addr_beat),
      .io_in_1_bits_payload_is_builtin_type(in1.payload.is_builtin_type),
      .io_in_1_bits_payload_a_type(in1.payload.a_type),
      .io_in_1_bits_payload_union(in1.payload.union_bits),
      .io_in_1_bits_payload_data(in1.payload.data),
      .io_out_ready(out_ready), .io_out_valid(out_valid),
      .io_out_bits_header_src(out_src), .io_out_bits_header_dst(out_dst),
      .io_out_bits_payload_addr_block(out_addr_block),
      .io_out_bits_payload_client_xact_id(out_xact),
      .io_out_bits_payload_addr_beat(out_beat),
      .io_out_bits_payload_is_builtin_type(out_builtin),
      .io_out_bits_payload_a_type(out_atype),
      .io_out_bits_payload_union(out_union),
      .io_out_bits_payload_data(out_data),
      .io_lock_active(lock)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // multi=1 drives a putBlock (a_type 3), otherwise a getType (a_type 0); src carries the client index.
   task automatic drive(input int unsigned idx, input logic v, input logic [2:0] beat,
                        input logic multi, input logic [63:0] d);
      net_acquire_t p;
      p.src                     = idx[1:0];
      p.dst                     = 2'd0;
      p.payload.addr_block      = 26'h100 + idx[25:0];
      p.payload.client_xact_id  = idx[0];
      p.payload.addr_beat       = beat;
      p.payload.is_builtin_type = 1'b1;
      p.payload.a_type          = multi ? ACQ_PUT_BLOCK : 3'h0;
      p.payload.union_bits      = d[11:0];
      p.payload.data            = d;
      if (idx == 0) begin in0 = p; v0 = v; end
      else          begin in1 = p; v1 = v; end
   endtask

   task automatic check_out(input string tag, input logic [1:0] src, input logic [63:0] d);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_src"},   64'(out_src),   64'(src));
      check({tag, "_data"},  out_data,       d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      out_ready = 1'b1;
      drive(0, 1'b1, 3'd0, 1'b0, 64'hA0);
      drive(1, 1'b1, 3'd0, 1'b0, 64'hB1);

      // Reset values with both inputs valid
      @(negedge clk); #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_r0", 64'(r0), 64'd0);
      check("rst_r1", 64'(r1), 64'd0);
      check("rst_lock", 64'(lock), 64'd0);

      // Single-beat interleave starting with client 0
      @(negedge clk); reset = 1'b0; #1;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin @(negedge clk); #1; end
         if (k == 4) begin v0 = 1'b0; v1 = 1'b0; #1; end
         else begin
            check("il_r0", 64'(r0), 64'((k % 2) == 0));
            check("il_r1", 64'(r1), 64'((k % 2) == 1));
         end
         if (k == 0) check("il_empty", 64'(out_valid), 64'd0);
         else check_out("il_out", 2'((k - 1) % 2), ((k - 1) % 2) == 0 ? 64'hA0 : 64'hB1);
      end
      check("il_union", 64'(out_union), 64'hB1);
      check("il_dst", 64'(out_dst), 64'd0);

      // putBlock lock from client 1; client 0 waits from beat 2
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (j < 8) drive(1, 1'b1, 3'(j), 1'b1, 64'h1000 + 64'(j));
         else v1 = 1'b0;
         if (j == 2) drive(0, 1'b1, 3'd0, 1'b0, 64'hC0);
         if (j == 9) v0 = 1'b0;
         #1;
         if (j < 8) begin
            check("lk_r1", 64'(r1), 64'd1);
            check("lk_r0", 64'(r0), 64'd0);
         end
         if (j == 8) check("lk_rel_r0", 64'(r0), 64'd1);
         check("lk_active", 64'(lock), 64'(j >= 1 && j <= 7));
         if (j >= 1 && j <= 8) begin
            check_out("lk_out", 2'd1, 64'h1000 + 64'(j - 1));
            check("lk_beat", 64'(out_beat), 64'(j - 1));
         end
         if (j == 9) check_out("lk_after", 2'd0, 64'hC0);
      end

      // Backpressure: out_ready low for 5 cycles
      for (int s = 0; s < 9; s++) begin
         @(negedge clk);
         out_ready = (s >= 5);
         if (s <= 2) drive(0, 1'b1, 3'd0, 1'b0, 64'h200 + 64'(s));
         if (s == 7) v0 = 1'b0;
         #1;
         if (s <= 6) check("bp_r0", 64'(r0), 64'(s < 2 || s == 6));
         if (s >= 1 && s <= 5) check_out("bp_hold", 2'd0, 64'h200);
         if (s == 6) check_out("bp_second", 2'd0, 64'h201);
         if (s == 7) check_out("bp_third", 2'd0, 64'h202);
         if (s == 8) check("bp_empty", 64'(out_valid), 64'd0);
      end

      // Streaming at count==1: one beat in and one out per cycle
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k < 10) drive(0, 1'b1, 3'd0, 1'b0, 64'h300 + 64'(k));
         else v0 = 1'b0;
         #1;
         if (k < 10) check("st_r0", 64'(r0), 64'd1);
         if (k >= 1 && k <= 10) check_out("st_out", 2'd0, 64'h300 + 64'(k - 1));
         if (k == 11) check("st_empty", 64'(out_valid), 64'd0);
      end

      // Degenerate putBlock beat 7 from client 0 must not lock
      @(negedge clk); drive(0, 1'b1, 3'd7, 1'b1, 64'h470); #1;
      check("dg_r0", 64'(r0), 64'd1);
      @(negedge clk);
      drive(0, 1'b1, 3'd0, 1'b0, 64'h400);
      drive(1, 1'b1, 3'd0, 1'b0, 64'h401); #1;
      check("dg_lock", 64'(lock), 64'd0);
      check("dg_r1", 64'(r1), 64'd1);
      check("dg_r0", 64'(r0), 64'd0);
      check_out("dg_out", 2'd0, 64'h470);
      @(negedge clk); v1 = 1'b0; #1;
      check("dg_next_r0", 64'(r0), 64'd1);
      check_out("dg_out1", 2'd1, 64'h401);
      @(negedge clk); v0 = 1'b0; #1;
      check_out("dg_out0", 2'd0, 64'h400);

      // Reset mid-burst after beat 3
      for (int j = 0; j < 4; j++) begin
         @(negedge clk); drive(1, 1'b1, 3'(j), 1'b1, 64'h500 + 64'(j)); #1;
         check("rb_r1", 64'(r1), 64'd1);
      end
      @(negedge clk);
      drive(1, 1'b1, 3'd4, 1'b1, 64'h504);
      drive(0, 1'b1, 3'd0, 1'b0, 64'h600); #1;
      check("rb_lock", 64'(lock), 64'd1);
      check("rb_r0_blocked", 64'(r0), 64'd0);
      check_out("rb_beat3", 2'd1, 64'h503);
      #1 reset = 1'b1; #1;
      check("rb_out_valid", 64'(out_valid), 64'd0);
      check("rb_lock_clr", 64'(lock), 64'd0);
      check("rb_r0_rst", 64'(r0), 64'd0);
      check("rb_r1_rst", 64'(r1), 64'd0);
      @(negedge clk); reset = 1'b0; #1;
      check("rb_post_r0", 64'(r0), 64'd1);
      check("rb_post_r1", 64'(r1), 64'd0);
      check("rb_post_lock", 64'(lock), 64'd0);
      @(negedge clk); v0 = 1'b0; v1 = 1'b0; #1;
      check_out("rb_post_out", 2'd0, 64'h600);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
